// File: rtl/dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// dma_engine : word-granular copy/fill DMA responder on a req/gnt memory port
// Revision   : 1.0
// ---------------------------------------------------------------------------
module dma_engine #(
    parameter int XLEN  = 32,
    parameter int LEN_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dma_en_i,
    input  logic [2:0]       dma_funct3_i,
    input  logic [LEN_W-1:0] dma_imm_i,
    input  logic [XLEN-1:0]  dma_rs1_i,
    input  logic [XLEN-1:0]  dma_rs2_i,
    output logic             dma_busy_o,
    output logic             dma_done_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_wr_data_o,
    output logic [3:0]       mem_size_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    input  logic [XLEN-1:0]  mem_rd_data_i
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RD_REQ  = 3'd1;
    localparam logic [2:0] c_RD_DATA = 3'd2;
    localparam logic [2:0] c_WR_REQ  = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam logic [2:0]      c_OP_COPY   = 3'b000;
    localparam logic [2:0]      c_OP_FILL   = 3'b001;
    localparam logic [XLEN-1:0] c_WORD      = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MSK = ~XLEN'(3);

    logic [2:0]       state_q, state_d;
    logic [XLEN-1:0]  src_q, src_d;
    logic [XLEN-1:0]  dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  buf_q, buf_d;
    logic             fill_q, fill_d;

    logic w_rd_acc;
    logic w_wr_acc;
    logic w_legal;

    assign w_legal = (dma_funct3_i == c_OP_COPY) || (dma_funct3_i == c_OP_FILL);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        case (state_q)
            c_IDLE: begin
                if (dma_en_i && w_legal) begin
                    src_d  = dma_rs1_i & c_ALIGN_MSK;
                    dst_d  = dma_rs2_i & c_ALIGN_MSK;
                    cnt_d  = dma_imm_i;
                    fill_d = (dma_funct3_i == c_OP_FILL);
                    if (dma_imm_i == '0) begin
                        state_d = c_DONE;
                    end else if (dma_funct3_i == c_OP_FILL) begin
                        buf_d   = dma_rs1_i;
                        state_d = c_WR_REQ;
                    end else begin
                        state_d = c_RD_REQ;
                    end
                end
            end
            c_RD_REQ: begin
                if (mem_gnt_i) begin
                    src_d   = src_q + c_WORD;
                    state_d = c_RD_DATA;
                end
            end
            c_RD_DATA: begin
                buf_d   = mem_rd_data_i;
                state_d = c_WR_REQ;
            end
            c_WR_REQ: begin
                if (mem_gnt_i) begin
                    dst_d = dst_q + c_WORD;
                    cnt_d = cnt_q - LEN_W'(1);
                    // Fill keeps the same pattern in buf_q, so it streams writes back to back.
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = c_DONE;
                    end else if (fill_q) begin
                        state_d = c_WR_REQ;
                    end else begin
                        state_d = c_RD_REQ;
                    end
                end
            end
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= c_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs decode the state register only, so reset forces them low at once.
    assign w_rd_acc      = (state_q == c_RD_REQ);
    assign w_wr_acc      = (state_q == c_WR_REQ);
    assign mem_req_o     = w_rd_acc | w_wr_acc;
    assign mem_read_o    = w_rd_acc;
    assign mem_write_o   = w_wr_acc;
    assign mem_addr_o    = w_rd_acc ? src_q : (w_wr_acc ? dst_q : '0);
    assign mem_wr_data_o = w_wr_acc ? buf_q : '0;
    assign mem_size_o    = (w_rd_acc | w_wr_acc) ? 4'b1111 : 4'b0000;
    assign dma_busy_o    = (state_q != c_IDLE);
    assign dma_done_o    = (state_q == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_dma_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dma_engine : randomized bench with a transaction-level model of dma_engine
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_dma_engine;
    localparam int XLEN  = 32;
    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       funct3;
    logic [LEN_W-1:0] imm;
    logic [XLEN-1:0]  rs1, rs2;
    logic             busy, done, req, gnt, rd, wr;
    logic [XLEN-1:0]  addr, wdata, rdata;
    logic [3:0]       size;

    dma_engine #(.XLEN(XLEN), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dma_en_i(en), .dma_funct3_i(funct3),
        .dma_imm_i(imm), .dma_rs1_i(rs1), .dma_rs2_i(rs2),
        .dma_busy_o(busy), .dma_done_o(done), .mem_req_o(req), .mem_gnt_i(gnt),
        .mem_addr_o(addr), .mem_wr_data_o(wdata), .mem_size_o(size),
        .mem_read_o(rd), .mem_write_o(wr), .mem_rd_data_i(rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          vectors = 0, miscompares = 0;
    int          busy_rem = 0, start_len = 0;
    bit          start_flag = 1'b0;
    int          stall_w = 0, stall_cnt = 0;
    bit          pend_rd = 1'b0;
    logic [31:0] pend_addr = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    int          busy_cycles = 0, done_cnt = 0, wr_granted = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, memory responder and grant driver.
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (start_flag) begin
                busy_rem   = start_len;
                start_flag = 1'b0;
            end
            check("busy", 32'(busy), 32'(busy_rem > 0));
            check("done", 32'(done), 32'(busy_rem == 1));
            if (busy_rem > 0) busy_rem--;
            if (busy) busy_cycles++;
            if (done) done_cnt++;
            check("size", 32'(size), req ? 32'hF : 32'h0);
            check("rw_onehot", 32'(rd) + 32'(wr), 32'(req));
            check("req_when_idle", 32'(req & ~busy), 32'h0);
            if (req) check("align", 32'(addr[1:0]), 32'h0);
            if (prev_stall) begin
                check("hold_req", 32'(req), 32'h1);
                check("hold_addr", addr, prev_addr);
                check("hold_rd", 32'(rd), 32'(prev_rd));
                check("hold_wr", 32'(wr), 32'(prev_wr));
                if (prev_wr) check("hold_wdata", wdata, prev_wdata);
            end
            rdata   = pend_rd ? rdmem(pend_addr) : $urandom;
            pend_rd = 1'b0;
            if (req) begin
                if (stall_cnt < stall_w) begin
                    gnt = 1'b0;
                    stall_cnt++;
                end else begin
                    gnt = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                gnt = 1'($urandom_range(0, 1));
            end
            prev_stall = req && !gnt;
            prev_addr  = addr;
            prev_wdata = wdata;
            prev_rd    = rd;
            prev_wr    = wr;
            if (req && gnt) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", addr, 32'hFFFF_FFFF ^ addr);
                end else begin
                    e = exp_q.pop_front();
                    check("acc_dir", 32'(wr), 32'(e.wr));
                    check("acc_addr", addr, e.addr);
                    if (wr) check("acc_data", wdata, e.data);
                end
                if (wr) begin
                    mem[addr] = wdata;
                    wr_granted++;
                end else begin
                    pend_rd   = 1'b1;
                    pend_addr = addr;
                end
            end
        end
    end

    // Builds the expected access list and busy length from the operation's rules.
    task automatic issue_cmd(input logic [2:0] f3, input int n, input logic [31:0] a1,
                             input logic [31:0] a2, input int w, output int len);
        logic [31:0] sh [logic [31:0]];
        logic [31:0] s, d, v;
        bit          legal;
        legal   = (f3 == 3'b000) || (f3 == 3'b001);
        stall_w = w;
        sh      = mem;
        s       = a1 & ~32'h3;
        d       = a2 & ~32'h3;
        len     = 0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                if (f3 == 3'b000) begin
                    v = sh.exists(s) ? sh[s] : dflt(s);
                    exp_q.push_back('{wr: 1'b0, addr: s, data: 32'h0});
                    exp_q.push_back('{wr: 1'b1, addr: d, data: v});
                    sh[d] = v;
                end else begin
                    exp_q.push_back('{wr: 1'b1, addr: d, data: a1});
                end
                s = s + 32'd4;
                d = d + 32'd4;
            end
            if (n == 0)             len = 1;
            else if (f3 == 3'b000)  len = n * (2 * (w + 1) + 1) + 1;
            else                    len = n * (w + 1) + 1;
        end
        @(negedge clk); #2;
        busy_cycles = 0;
        done_cnt    = 0;
        wr_granted  = 0;
        en          = 1'b1;
        funct3      = f3;
        imm         = LEN_W'(n);
        rs1         = a1;
        rs2         = a2;
        start_len   = len;
        start_flag  = 1'b1;
        @(negedge clk); #2;
        en     = 1'b0;
        funct3 = 3'($urandom);
        imm    = LEN_W'($urandom);
        rs1    = $urandom;
        rs2    = $urandom;
    endtask

    task automatic run_cmd(input logic [2:0] f3, input int n, input logic [31:0] a1,
                           input logic [31:0] a2, input int w);
        int len;
        issue_cmd(f3, n, a1, a2, w, len);
        repeat (len + 2) @(negedge clk);
        #2;
        check("busy_len", 32'(busy_cycles), 32'(len));
        check("done_cnt", 32'(done_cnt), 32'((f3 == 3'b000 || f3 == 3'b001) ? 1 : 0));
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic check_outputs_zero();
        check("z_busy", 32'(busy), 32'h0);
        check("z_done", 32'(done), 32'h0);
        check("z_req", 32'(req), 32'h0);
        check("z_addr", addr, 32'h0);
        check("z_wdata", wdata, 32'h0);
        check("z_size", 32'(size), 32'h0);
        check("z_rd", 32'(rd), 32'h0);
        check("z_wr", 32'(wr), 32'h0);
    endtask

    initial begin
        int          len;
        bit          found;
        int          r, n, w;
        logic [2:0]  f3;
        logic [31:0] a1, a2;

        rst_n = 1'b0; en = 1'b0; funct3 = '0; imm = '0; rs1 = '0; rs2 = '0;
        gnt = 1'b0; rdata = '0;
        #1;
        check_outputs_zero();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        mem[32'h100] = 32'hAAAA_0001;
        mem[32'h104] = 32'hBBBB_0002;
        mem[32'h108] = 32'hCCCC_0003;
        run_cmd(3'b000, 3, 32'h100, 32'h200, 0);
        check("lit_copy_busy", 32'(busy_cycles), 32'd10);
        check("lit_copy_w0", rdmem(32'h200), 32'hAAAA_0001);
        check("lit_copy_w1", rdmem(32'h204), 32'hBBBB_0002);
        check("lit_copy_w2", rdmem(32'h208), 32'hCCCC_0003);

        run_cmd(3'b001, 4, 32'hDEAD_BEEF, 32'h303, 0);
        check("lit_fill_busy", 32'(busy_cycles), 32'd5);
        check("lit_fill_first", rdmem(32'h300), 32'hDEAD_BEEF);
        check("lit_fill_last", rdmem(32'h30C), 32'hDEAD_BEEF);

        mem[32'h600] = 32'h1234_5678;
        mem[32'h604] = 32'h9ABC_DEF0;
        run_cmd(3'b000, 2, 32'h600, 32'h700, 3);
        check("lit_stall_busy", 32'(busy_cycles), 32'd19);
        check("lit_stall_w1", rdmem(32'h704), 32'h9ABC_DEF0);

        run_cmd(3'b000, 0, 32'h100, 32'h200, 0);
        check("lit_n0_busy", 32'(busy_cycles), 32'd1);
        check("lit_n0_done", 32'(done_cnt), 32'd1);

        run_cmd(3'b111, 5, 32'h100, 32'h200, 0);
        check("lit_illegal_busy", 32'(busy_cycles), 32'd0);

        run_cmd(3'b001, 2, 32'h5A5A_0F0F, 32'hFFFF_FFFC, 1);
        check("lit_wrap_hi", rdmem(32'hFFFF_FFFC), 32'h5A5A_0F0F);
        check("lit_wrap_lo", rdmem(32'h0000_0000), 32'h5A5A_0F0F);

        // Abort a 4-word copy while its second write is waiting for grant.
        issue_cmd(3'b000, 4, 32'h400, 32'h500, 5, len);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk); #2;
            if (wr_granted == 1 && req && wr) found = 1'b1;
        end
        check("reset_point_reached", 32'(found), 32'h1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero();
        exp_q.delete();
        busy_rem   = 0;
        start_flag = 1'b0;
        pend_rd    = 1'b0;
        prev_stall = 1'b0;
        stall_cnt  = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_no_done", 32'(done_cnt), 32'h0);
        run_cmd(3'b000, 2, 32'h100, 32'h800, 0);
        check("lit_post_reset", rdmem(32'h804), 32'hBBBB_0002);

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            n = $urandom_range(0, 6);
            w = $urandom_range(0, 3);
            if (r < 4) begin
                f3 = 3'b000;
                a1 = 32'h1000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            end else if (r < 8) begin
                f3 = 3'b001;
                a1 = $urandom;
            end else begin
                f3 = 3'($urandom_range(2, 7));
                a1 = $urandom;
            end
            if ($urandom_range(0, 7) == 0)
                a2 = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                a2 = 32'h1000 + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
            run_cmd(f3, n, a1, a2, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dma_engine.md
Name: dma_engine

Overview:
Word-granular DMA responder for the core's custom DMA instruction interface. It accepts the one-cycle command pulse from the core's EX stage and holds the core stalled through its busy output. It moves data over a request/grant data-memory port shared with the core's load/store path. Two operations are supported: memory copy and memory fill.

Parameters:
XLEN, 32, data/address width
LEN_W, 12, width of the transfer length field (words)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
dma_en_i  input  1  command strobe, asserted for exactly one cycle by the core
dma_funct3_i  input  3  operation: 3'b000 copy, 3'b001 fill, others illegal
dma_imm_i  input  LEN_W  transfer length in 32-bit words
dma_rs1_i  input  XLEN  copy: source address; fill: fill pattern
dma_rs2_i  input  XLEN  destination address
dma_busy_o  output  1  engine active; the core stalls while high
dma_done_o  output  1  one-cycle pulse on completion
mem_req_o  output  1  request for the data-memory port
mem_gnt_i  input  1  grant; the access is performed in the cycle where req && gnt
mem_addr_o  output  XLEN  word address, bits [1:0] always 0
mem_wr_data_o  output  XLEN  store data
mem_size_o  output  4  byte enables, always 4'b1111 when accessing, else 0
mem_read_o  output  1  read access (valid only with mem_req_o)
mem_write_o  output  1  write access (valid only with mem_req_o)
mem_rd_data_i  input  XLEN  read data, valid the cycle after a granted read

Behaviour:
- Reset: state IDLE. All outputs 0. Internal src/dst/count/buffer registers cleared.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, DONE.
- dma_busy_o = (state != IDLE). Registered from the state, so it rises the cycle after dma_en_i.
- IDLE, dma_en_i with legal funct3:
  - latch src = {rs1[31:2],2'b00}, dst = {rs2[31:2],2'b00}, pattern = rs1, count = imm.
  - count==0 -> DONE.
  - copy -> RD_REQ.
  - fill -> WR_REQ, with buffer = pattern.
- IDLE, dma_en_i with illegal funct3: ignored. No busy, no done.
- dma_en_i outside IDLE: ignored. The core cannot issue one while stalled.
- RD_REQ:
  - mem_req_o=1, mem_read_o=1, mem_addr_o=src.
  - Hold until mem_gnt_i; on grant -> RD_DATA, src += 4.
- RD_DATA: no request. Capture buffer <= mem_rd_data_i -> WR_REQ.
- WR_REQ:
  - mem_req_o=1, mem_write_o=1, mem_addr_o=dst, mem_wr_data_o=buffer.
  - On grant: dst += 4, count -= 1.
  - If the new count==0 -> DONE; else copy -> RD_REQ, fill -> stay in WR_REQ.
- DONE: dma_done_o=1 for one cycle -> IDLE. Busy is high during DONE.
- Address arithmetic is modulo 2^XLEN. 0xFFFF_FFFC + 4 wraps to 0x0000_0000 with no error.
- Request/address/data are held stable while mem_gnt_i=0. No timeout.
- Throughput with gnt tied high:
  - copy = 3 cycles/word; fill = 1 cycle/word.
  - busy cycles: copy = 3N+1, fill = N+1, N=0 -> 1.
- Overlapping source and destination regions are copied in ascending address order. No overlap correction.
- Asynchronous reset mid-transfer aborts immediately to IDLE with outputs 0. No done pulse is produced.

Test Plan:
- Copy N=3, rs1=0x100, rs2=0x200, gnt=1, mem[0x100..0x108]={A,B,C} -> reads 0x100,0x104,0x108 and writes 0x200,0x204,0x208 = A,B,C; busy high 10 cycles; done on the final busy cycle.
- Fill N=4, rs1=0xDEADBEEF, rs2=0x303 -> writes at 0x300,0x304,0x308,0x30C all 0xDEADBEEF; mem_size_o=4'b1111; busy 5 cycles.
- Copy N=2 with gnt low 3 cycles on each request -> addr/data/read/write held stable while waiting; data correct; busy = 7+12 = 19 cycles.
- N=0 copy -> no mem_req_o; busy exactly 1 cycle, coinciding with done. funct3=3'b111 -> busy and done never assert.
- Fill N=2, rs2=0xFFFF_FFFC -> writes at 0xFFFF_FFFC then 0x0000_0000.
- Reset asserted during the second WR_REQ of a 4-word copy -> all outputs 0 immediately, no done; a new command afterwards runs normally.
